// File: rtl/recip_engine.sv
// Reciprocal engine: reads a 16-bit divisor from byte memory, computes floor(32768/divisor)
// by restoring division and writes the 16-bit quotient back, handshaking with Start/Ack.
module recip_engine #(
  parameter int unsigned DIVISOR_ADDR = 8,
  parameter int unsigned RESULT_ADDR  = 10
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  output logic       ack_o,
  output logic       busy_o,
  output logic [7:0] mem_addr_o,
  input  logic [7:0] mem_rd_data_i,
  output logic       mem_wr_en_o,
  output logic [7:0] mem_wr_data_o
);

  localparam logic [7:0] DivHiAddr = 8'(DIVISOR_ADDR);
  localparam logic [7:0] DivLoAddr = 8'(DIVISOR_ADDR + 1);
  localparam logic [7:0] ResHiAddr = 8'(RESULT_ADDR);
  localparam logic [7:0] ResLoAddr = 8'(RESULT_ADDR + 1);

  typedef enum logic [2:0] {
    StIdle, StArmed, StRdHi, StRdLo, StDiv, StWrHi, StWrLo, StDone
  } state_e;

  state_e      state_q;
  logic [15:0] divisor_q;
  logic [15:0] quot_q;
  logic [16:0] rem_q;
  logic [3:0]  cnt_q;
  logic        ack_q;
  logic        busy_q;
  logic [7:0]  addr_q;
  logic        wr_en_q;
  logic [7:0]  wr_data_q;

  logic [16:0] rem_shift;
  logic        rem_ge;
  logic [16:0] rem_next;
  logic [15:0] quot_next;
  logic [15:0] divisor_full;

  // Dividend is 16'h8000, so only the first (MSB) step shifts in a one.
  always_comb begin
    rem_shift    = {rem_q[15:0], (cnt_q == 4'd15)};
    rem_ge       = (rem_shift >= {1'b0, divisor_q});
    rem_next     = rem_ge ? (rem_shift - {1'b0, divisor_q}) : rem_shift;
    quot_next    = {quot_q[14:0], rem_ge};
    divisor_full = {divisor_q[15:8], mem_rd_data_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      divisor_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) state_q <= StArmed;
        end
        StArmed: begin
          if (!start_i) begin
            state_q <= StRdHi;
            addr_q  <= DivHiAddr;
            busy_q  <= 1'b1;
          end
        end
        StRdHi: begin
          divisor_q[15:8] <= mem_rd_data_i;
          addr_q          <= DivLoAddr;
          state_q         <= StRdLo;
        end
        StRdLo: begin
          divisor_q[7:0] <= mem_rd_data_i;
          if (divisor_full != 16'd0) begin
            state_q <= StDiv;
            cnt_q   <= 4'd15;
            rem_q   <= '0;
            quot_q  <= '0;
          end else begin
            // Zero divisor short-circuits to a fixed quotient of one.
            quot_q    <= 16'h0001;
            state_q   <= StWrHi;
            addr_q    <= ResHiAddr;
            wr_data_q <= 8'h00;
            wr_en_q   <= 1'b1;
          end
        end
        StDiv: begin
          rem_q  <= rem_next;
          quot_q <= quot_next;
          if (cnt_q == 4'd0) begin
            state_q   <= StWrHi;
            addr_q    <= ResHiAddr;
            wr_data_q <= quot_next[15:8];
            wr_en_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StWrHi: begin
          addr_q    <= ResLoAddr;
          wr_data_q <= quot_q[7:0];
          state_q   <= StWrLo;
        end
        StWrLo: begin
          wr_en_q <= 1'b0;
          busy_q  <= 1'b0;
          ack_q   <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          if (start_i) begin
            ack_q   <= 1'b0;
            state_q <= StArmed;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack_o         = ack_q;
  assign busy_o        = busy_q;
  assign mem_addr_o    = addr_q;
  assign mem_wr_en_o   = wr_en_q;
  assign mem_wr_data_o = wr_data_q;

endmodule

// File: tb/tb_recip_engine.sv
// Directed bench for recip_engine with a byte-memory model and write-strobe counter.
module tb_recip_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ack, busy, wr_en;
  logic [7:0] addr, rd_data, wr_data;

  logic       tb_we = 1'b0;
  logic [7:0] tb_wa = '0;
  logic [7:0] tb_wd = '0;
  logic [7:0] mem [256];
  int         wr_cnt = 0;

  int checks = 0;
  int failures = 0;
  int lat;
  int base;

  always #5 clk = ~clk;

  recip_engine #(.DIVISOR_ADDR(8), .RESULT_ADDR(10)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .ack_o         (ack),
    .busy_o        (busy),
    .mem_addr_o    (addr),
    .mem_rd_data_i (rd_data),
    .mem_wr_en_o   (wr_en),
    .mem_wr_data_o (wr_data)
  );

  assign rd_data = mem[addr];

  always @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
      wr_cnt    <= wr_cnt + 1;
    end else if (tb_we) begin
      mem[tb_wa] <= tb_wd;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  // Counts edges after launch edge L (n0 already consumed) until Ack is seen.
  task automatic wait_ack(input int n0, output int n);
    n = n0;
    while (ack !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Start 1 -> 0; returns just after launch edge L.
  task automatic launch();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_run(input string tag, input logic [15:0] dv, input logic [15:0] q,
                        input int exp_lat);
    poke(8'd8, dv[15:8]);
    poke(8'd9, dv[7:0]);
    base = wr_cnt;
    launch();
    wait_ack(0, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_q"}, {mem[10], mem[11]}, q);
    check({tag, "_writes"}, wr_cnt - base, 2);
  endtask

  initial begin
    start = 1'b0;
    #1;
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_wren", wr_en, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wr_data, 0);
    poke(8'd8, 8'h00);
    poke(8'd9, 8'h24);
    poke(8'd10, 8'hAA);
    poke(8'd11, 8'hBB);

    // Start already high when reset releases: first edge arms.
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("armed_busy", busy, 0);
    start = 1'b0;
    base = wr_cnt;
    @(posedge clk); #1;
    check("launch_busy", busy, 1);
    check("launch_addr", addr, 8);
    wait_ack(0, lat);
    check("d24_lat", lat, 20);
    check("d24_hi", mem[10], 8'h03);
    check("d24_lo", mem[11], 8'h8E);
    check("d24_writes", wr_cnt - base, 2);
    check("done_busy", busy, 0);

    do_run("d4", 16'h0004, 16'h2000, 20);
    do_run("d1", 16'h0001, 16'h8000, 20);
    do_run("d8000", 16'h8000, 16'h0001, 20);
    do_run("dffff", 16'hFFFF, 16'h0000, 20);
    do_run("d0", 16'h0000, 16'h0001, 4);

    // Reset during DIV aborts with no writes.
    poke(8'd10, 8'hAA);
    poke(8'd11, 8'hBB);
    poke(8'd8, 8'h00);
    poke(8'd9, 8'h24);
    base = wr_cnt;
    launch();
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_ack", ack, 0);
    check("abort_wren", wr_en, 0);
    check("abort_addr", addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("abort_mem", {mem[10], mem[11]}, 16'hAABB);
    check("abort_writes", wr_cnt - base, 0);
    check("abort_idle_ack", ack, 0);
    do_run("d7", 16'h0007, 16'h1249, 20);

    // Start held high through completion rearms; then launch with divisor 3.
    poke(8'd8, 8'h00);
    poke(8'd9, 8'h05);
    base = wr_cnt;
    launch();
    start = 1'b1;
    wait_ack(0, lat);
    check("hold_lat", lat, 20);
    check("hold_q", {mem[10], mem[11]}, 16'h1999);
    check("hold_writes", wr_cnt - base, 2);
    @(posedge clk); #1;
    check("hold_ack_drop", ack, 0);
    check("hold_armed_busy", busy, 0);
    poke(8'd9, 8'h03);
    check("hold_still_armed", busy, 0);
    base = wr_cnt;
    start = 1'b0;
    @(posedge clk); #1;
    wait_ack(0, lat);
    check("d3_lat", lat, 20);
    check("d3_q", {mem[10], mem[11]}, 16'h2AAA);
    check("d3_writes", wr_cnt - base, 2);

    // Start toggling while busy is ignored.
    poke(8'd9, 8'h24);
    poke(8'd10, 8'h00);
    poke(8'd11, 8'h00);
    base = wr_cnt;
    launch();
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      start = (i % 2 == 0);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    wait_ack(lat, lat);
    check("tog_lat", lat, 20);
    check("tog_q", {mem[10], mem[11]}, 16'h038E);
    check("tog_writes", wr_cnt - base, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
